// File: rtl/shared_flux_fifo_v2.sv
// shared_flux_fifo_v2: one DEPTH-entry storage array shared among FLUX flows.
// Each flow is a linked list threaded through a next-pointer array. Free slots
// are tracked by a busy bitmap. Each flow has RESERVE guaranteed slots, and the
// remaining slots form a shared pool. Every flow has its own registered read
// port with a valid strobe.
module shared_flux_fifo_v2 #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int FLUX    = 2,
  parameter int RESERVE = 1
) (
  input  logic                                   ck,
  input  logic                                   rst,
  input  logic                                   wr,
  input  logic [WIDTH-1:0]                       datain,
  input  logic [FLUX-1:0]                        rd,
  output logic [FLUX-1:0]                        full,
  output logic [FLUX-1:0]                        empty,
  output logic [FLUX*($clog2(DEPTH)+1)-1:0]      count,
  output logic [FLUX*WIDTH-1:0]                  dataout,
  output logic [FLUX-1:0]                        dout_valid,
  output logic                                   overflow,
  output logic                                   tag_err
);

  localparam int TAG_WIDTH  = $clog2(FLUX);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam int SHARED_CAP = DEPTH - FLUX * RESERVE;

  logic [WIDTH-1:0]      r_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] r_nxt  [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [ADDR_WIDTH-1:0] r_head [FLUX];
  logic [ADDR_WIDTH-1:0] r_tail [FLUX];
  logic [CNT_WIDTH-1:0]  r_cnt  [FLUX];
  logic [FLUX*WIDTH-1:0] r_dataout;
  logic [FLUX-1:0]       r_dout_valid;
  logic                  r_overflow;
  logic                  r_tag_err;

  logic [TAG_WIDTH-1:0]  w_tag;
  logic                  w_tag_ok;
  logic                  w_tag_full;
  logic [FLUX-1:0]       w_empty;
  logic [FLUX-1:0]       w_full;
  logic [CNT_WIDTH-1:0]  w_shared;
  logic [ADDR_WIDTH-1:0] w_slot;
  logic                  w_slot_ok;
  logic                  w_wr_acc;
  logic                  w_overflow;
  logic                  w_tag_err;
  logic [FLUX-1:0]       w_wr_sel;
  logic [FLUX-1:0]       w_rd_acc;
  logic [FLUX-1:0]       w_new_head;
  logic [FLUX-1:0]       w_link;
  logic                  w_link_ok;
  logic [ADDR_WIDTH-1:0] w_link_addr;
  logic [DEPTH-1:0]      w_busy_next;

  // Occupancy flags and shared-pool usage. full depends on registered state only.
  always_comb begin
    w_shared = '0;
    w_empty  = '0;
    w_full   = '0;
    for (int unsigned i = 0; i < FLUX; i++) begin
      w_empty[i] = (r_cnt[i] == '0);
      if (r_cnt[i] > CNT_WIDTH'(RESERVE))
        w_shared = w_shared + (r_cnt[i] - CNT_WIDTH'(RESERVE));
    end
    for (int unsigned i = 0; i < FLUX; i++)
      w_full[i] = (r_cnt[i] >= CNT_WIDTH'(RESERVE)) &&
                  (w_shared == CNT_WIDTH'(SHARED_CAP));
  end

  // Lowest-index free slot, taken from the registered bitmap only.
  always_comb begin
    w_slot    = '0;
    w_slot_ok = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!r_busy[i] && !w_slot_ok) begin
        w_slot    = ADDR_WIDTH'(i);
        w_slot_ok = 1'b1;
      end
    end
  end

  // Write/read acceptance, list-linking decisions and next busy bitmap.
  always_comb begin
    w_tag      = datain[WIDTH-1 -: TAG_WIDTH];
    w_tag_ok   = (32'(w_tag) < 32'(FLUX));
    w_tag_full = 1'b0;
    for (int unsigned i = 0; i < FLUX; i++)
      if (w_tag == TAG_WIDTH'(i)) w_tag_full = w_full[i];
    w_rd_acc   = rd & ~w_empty;
    w_wr_acc   = wr && w_tag_ok && !w_tag_full && w_slot_ok;
    w_overflow = wr && w_tag_ok && w_tag_full;
    w_tag_err  = wr && !w_tag_ok;
    w_wr_sel   = '0;
    w_new_head = '0;
    w_link     = '0;
    w_link_ok  = 1'b0;
    w_link_addr = '0;
    w_busy_next = r_busy;
    for (int unsigned i = 0; i < FLUX; i++) begin
      w_wr_sel[i] = w_wr_acc && (w_tag == TAG_WIDTH'(i));
      // The list becomes empty before the write lands if it was empty, or if
      // its only word is being read out in the same cycle.
      w_new_head[i] = w_wr_sel[i] &&
                      (w_empty[i] || ((r_cnt[i] == CNT_WIDTH'(1)) && w_rd_acc[i]));
      w_link[i] = w_wr_sel[i] && !w_new_head[i];
      if (w_link[i]) begin
        w_link_ok   = 1'b1;
        w_link_addr = r_tail[i];
      end
      if (w_rd_acc[i]) w_busy_next[r_head[i]] = 1'b0;
    end
    if (w_wr_acc) w_busy_next[w_slot] = 1'b1;
  end

  // Storage and link array; not reset, and untouched during a reset edge.
  always_ff @(posedge ck) begin
    if (rst && w_wr_acc) begin
      r_mem[w_slot] <= datain;
      if (w_link_ok) r_nxt[w_link_addr] <= w_slot;
    end
  end

  // Per-flow pointers, counts, read ports, status pulses and busy bitmap.
  always_ff @(posedge ck) begin
    if (!rst) begin
      r_busy       <= '0;
      r_dataout    <= '0;
      r_dout_valid <= '0;
      r_overflow   <= 1'b0;
      r_tag_err    <= 1'b0;
      for (int unsigned i = 0; i < FLUX; i++) begin
        r_head[i] <= '0;
        r_tail[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      r_busy       <= w_busy_next;
      r_dout_valid <= w_rd_acc;
      r_overflow   <= w_overflow;
      r_tag_err    <= w_tag_err;
      for (int unsigned i = 0; i < FLUX; i++) begin
        if (w_rd_acc[i]) begin
          r_dataout[i*WIDTH +: WIDTH] <= r_mem[r_head[i]];
          r_head[i] <= r_nxt[r_head[i]];
        end
        if (w_new_head[i]) r_head[i] <= w_slot;
        if (w_wr_sel[i])   r_tail[i] <= w_slot;
        r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(w_wr_sel[i]) - CNT_WIDTH'(w_rd_acc[i]);
      end
    end
  end

  // Pack per-flow counts onto the flat count bus.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < FLUX; i++)
      count[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt[i];
  end

  assign full       = w_full;
  assign empty      = w_empty;
  assign dataout    = r_dataout;
  assign dout_valid = r_dout_valid;
  assign overflow   = r_overflow;
  assign tag_err    = r_tag_err;

endmodule

// File: tb/tb_shared_flux_fifo_v2.sv
// Bench for shared_flux_fifo_v2. A queue-based reference model produces one
// expectation record per clock edge, and a monitor compares each record on the
// following falling edge. A second instance with three flows exercises
// tag errors.
module tb_shared_flux_fifo_v2;

  localparam int D = 8;
  localparam int F = 2;
  localparam int R = 2;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  // Instance 1: WIDTH=8, DEPTH=8, FLUX=2, RESERVE=2
  logic        rst1, wr1;
  logic [7:0]  din1;
  logic [1:0]  rd1, full1, empty1, dv1;
  logic [7:0]  count1;
  logic [15:0] dout1;
  logic        ovf1, terr1;

  shared_flux_fifo_v2 #(.WIDTH(8), .DEPTH(D), .FLUX(F), .RESERVE(R)) dut1 (
    .ck(ck), .rst(rst1), .wr(wr1), .datain(din1), .rd(rd1),
    .full(full1), .empty(empty1), .count(count1), .dataout(dout1),
    .dout_valid(dv1), .overflow(ovf1), .tag_err(terr1)
  );

  // Instance 2: WIDTH=8, DEPTH=8, FLUX=3, RESERVE=1 (tag 3 is invalid)
  logic        rst2, wr2;
  logic [7:0]  din2;
  logic [2:0]  rd2, full2, empty2, dv2;
  logic [11:0] count2;
  logic [23:0] dout2;
  logic        ovf2, terr2;

  shared_flux_fifo_v2 #(.WIDTH(8), .DEPTH(8), .FLUX(3), .RESERVE(1)) dut2 (
    .ck(ck), .rst(rst2), .wr(wr2), .datain(din2), .rd(rd2),
    .full(full2), .empty(empty2), .count(count2), .dataout(dout2),
    .dout_valid(dv2), .overflow(ovf2), .tag_err(terr2)
  );

  typedef struct {
    logic [1:0]  vld;
    logic [15:0] data;
    logic        ovf;
    logic [1:0]  full;
    logic [1:0]  empty;
    logic [7:0]  cnt;
    int          tot;
  } exp_t;

  logic [7:0]  mq [F][$];
  logic [15:0] m_hold;
  exp_t        expq [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int shared_used();
    int s = 0;
    for (int f = 0; f < F; f++)
      if (mq[f].size() > R) s += mq[f].size() - R;
    return s;
  endfunction

  // One clock edge of stimulus plus the model's view of what follows it.
  task automatic step1(input logic r, input logic w, input logic [7:0] d, input logic [1:0] rdv);
    exp_t e;
    int   c [F];
    int   sh;
    int   tag;
    rst1 = r; wr1 = w; din1 = d; rd1 = rdv;
    e.vld = '0;
    e.ovf = 1'b0;
    if (!r) begin
      for (int f = 0; f < F; f++) mq[f].delete();
      m_hold = '0;
    end else begin
      for (int f = 0; f < F; f++) c[f] = mq[f].size();
      sh = shared_used();
      for (int f = 0; f < F; f++)
        if (rdv[f] && c[f] > 0) begin
          m_hold[f*8 +: 8] = mq[f].pop_front();
          e.vld[f] = 1'b1;
        end
      if (w) begin
        tag = int'(d[7]);
        if (c[tag] >= R && sh == D - F * R) e.ovf = 1'b1;
        else mq[tag].push_back(d);
      end
    end
    sh = shared_used();
    e.tot = 0;
    for (int f = 0; f < F; f++) begin
      e.empty[f]      = (mq[f].size() == 0);
      e.full[f]       = (mq[f].size() >= R) && (sh == D - F * R);
      e.cnt[f*4 +: 4] = 4'(mq[f].size());
      e.tot          += mq[f].size();
    end
    e.data = m_hold;
    @(posedge ck);
    expq.push_back(e);
    #1;
  endtask

  // Monitor for instance 1: compares the DUT against the expectation for the latest edge.
  always @(negedge ck) begin : mon
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("dout_valid", 32'(dv1), 32'(e.vld));
      chk("dataout", 32'(dout1), 32'(e.data));
      chk("overflow", 32'(ovf1), 32'(e.ovf));
      chk("tag_err", 32'(terr1), 32'(0));
      chk("full", 32'(full1), 32'(e.full));
      chk("empty", 32'(empty1), 32'(e.empty));
      chk("count", 32'(count1), 32'(e.cnt));
      chk("busy_popcount", 32'($countones(dut1.r_busy)), 32'(e.tot));
    end
  end

  initial begin
    logic [7:0] rd_data;
    logic [1:0] rd_mask;
    int         pr;
    rst1 = 1'b0; wr1 = 1'b0; din1 = '0; rd1 = '0;
    rst2 = 1'b0; wr2 = 1'b0; din2 = '0; rd2 = '0;
    m_hold = '0;

    // Reset, then one word per flow and a dual read.
    step1(1'b0, 1'b0, 8'h00, 2'b00);
    step1(1'b0, 1'b0, 8'h00, 2'b00);
    step1(1'b1, 1'b1, 8'h05, 2'b00);
    step1(1'b1, 1'b1, 8'h83, 2'b00);
    step1(1'b1, 1'b0, 8'h00, 2'b11);
    step1(1'b1, 1'b0, 8'h00, 2'b00);

    // Fill flow 0 through the shared pool, overflow, then fill flow 1's reserve.
    for (int i = 0; i < 6; i++) step1(1'b1, 1'b1, 8'(8'h10 + i), 2'b00);
    step1(1'b1, 1'b1, 8'h16, 2'b00);
    step1(1'b1, 1'b1, 8'h81, 2'b00);
    step1(1'b1, 1'b1, 8'h82, 2'b00);
    step1(1'b1, 1'b1, 8'h84, 2'b00);
    repeat (7) step1(1'b1, 1'b0, 8'h00, 2'b11);

    // Same-cycle read and write on a single-word flow; read of an empty flow with a write.
    step1(1'b1, 1'b1, 8'hA1, 2'b00);
    step1(1'b1, 1'b1, 8'hA2, 2'b10);
    step1(1'b1, 1'b1, 8'h31, 2'b01);
    step1(1'b1, 1'b0, 8'h00, 2'b11);
    step1(1'b1, 1'b0, 8'h00, 2'b00);

    // Random traffic: a read-light phase that presses against the quota, then a read-heavy phase.
    for (int i = 0; i < 1000; i++) begin
      pr = (i < 500) ? 25 : 60;
      rd_data = 8'($urandom);
      rd_mask[0] = ($urandom_range(0, 99) < pr);
      rd_mask[1] = ($urandom_range(0, 99) < pr);
      step1(1'b1, ($urandom_range(0, 99) < 60), rd_data, rd_mask);
    end

    // Fill, then a reset edge with write and reads asserted.
    for (int i = 0; i < 10; i++) step1(1'b1, 1'b1, 8'($urandom), 2'b00);
    step1(1'b0, 1'b1, 8'h12, 2'b11);
    step1(1'b1, 1'b0, 8'h00, 2'b00);
    step1(1'b1, 1'b0, 8'h00, 2'b11);
    @(negedge ck);
    #1;
    chk("scoreboard_drained", 32'(expq.size()), 32'(0));

    // Instance 2: invalid tag and reads of empty flows.
    @(posedge ck); #1;
    @(posedge ck); #1;
    rst2 = 1'b1; wr2 = 1'b1; din2 = 8'hC0;
    @(posedge ck); #1;
    wr2 = 1'b0;
    @(negedge ck);
    chk("f3_tag_err_pulse", 32'(terr2), 32'(1));
    chk("f3_overflow_quiet", 32'(ovf2), 32'(0));
    chk("f3_count_unchanged", 32'(count2), 32'(0));
    chk("f3_empty_all", 32'(empty2), 32'(3'b111));
    @(posedge ck); #1;
    @(negedge ck);
    chk("f3_tag_err_drop", 32'(terr2), 32'(0));
    @(posedge ck); #1;
    wr2 = 1'b1; din2 = 8'h45;
    @(posedge ck); #1;
    wr2 = 1'b0; rd2 = 3'b101;
    @(posedge ck); #1;
    rd2 = 3'b000;
    @(negedge ck);
    chk("f3_empty_read_no_strobe", 32'(dv2), 32'(0));
    chk("f3_count_after_write", 32'(count2), 32'(12'h010));
    chk("f3_empty_after_write", 32'(empty2), 32'(3'b101));
    @(posedge ck); #1;
    rd2 = 3'b010;
    @(posedge ck); #1;
    rd2 = 3'b000;
    @(negedge ck);
    chk("f3_read_strobe", 32'(dv2), 32'(3'b010));
    chk("f3_read_data", 32'(dout2[15:8]), 32'(8'h45));
    chk("f3_count_after_read", 32'(count2), 32'(0));
    @(posedge ck); #1;
    @(negedge ck);
    chk("f3_strobe_drop", 32'(dv2), 32'(0));
    chk("f3_data_hold", 32'(dout2[15:8]), 32'(8'h45));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
